// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared encodings for the EX-stage ALU and the iterative
// multiply/divide unit.
//   - ALU op codes (4-bit alu_op)
//   - md_op codes (MULT/MULTU/DIV/DIVU)
//   - mul/div FSM state encoding
package alu_md_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLLV = 4'b1011;
  localparam logic [3:0] ALU_SRLV = 4'b1100;
  localparam logic [3:0] ALU_SRAV = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: EX-stage bus between the pipeline controller and alu_md.
//   ALU:    alu_op, input_1, input_2, shamt -> alu_result, zero, more0, overflow
//   MD:     md_start, md_op                 -> md_busy, md_done
//   Moves:  hi_we, lo_we (write input_1)    -> hi, lo
// master = controller side, slave = alu_md.
interface alu_md_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic [3:0]         alu_op;
  logic [WIDTH-1:0]   input_1;
  logic [WIDTH-1:0]   input_2;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_result;
  logic               zero;
  logic               more0;
  logic               overflow;
  logic               md_start;
  logic [1:0]         md_op;
  logic               hi_we;
  logic               lo_we;
  logic               md_busy;
  logic               md_done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output alu_op, input_1, input_2, shamt, md_start, md_op, hi_we, lo_we,
    input  alu_result, zero, more0, overflow, md_busy, md_done, hi, lo
  );

  modport slave (
    input  alu_op, input_1, input_2, shamt, md_start, md_op, hi_we, lo_we,
    output alu_result, zero, more0, overflow, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/alu_md_iter.sv
// md_iter: iterative multiply/divide datapath with its step counter.
//   clk, reset_n     clock, synchronous active-low reset
//   start, op, a, b  request; taken whenever the unit is not in RUN
//   busy, done       registered handshake outputs
//   wr               high during the last RUN cycle; res_hi/res_lo are the
//                    final HI/LO values to capture on that edge
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add / restoring-subtract step per cycle, WIDTH cycles
// FIN   | HI/LO just updated, done=1; a new start is accepted here
module md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [SHAMT_W-1:0] CNT_LOAD = SHAMT_W'(WIDTH - 1);

  md_state_e          state;
  logic [SHAMT_W-1:0] cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  // m_op: multiplicand (mul) or divisor (div) magnitude.
  // p_hi/p_lo: partial product, or remainder/quotient for divide.
  logic [WIDTH-1:0]   m_op;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               borrow;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_c;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_op} : '0);
  assign div_sh   = {p_hi, p_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, m_op};
  assign borrow   = div_diff[WIDTH];

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = borrow ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {p_lo[WIDTH-2:0], ~borrow};
    end
  end

  assign prod   = {step_hi, step_lo};
  assign prod_c = neg_res ? -prod : prod;

  always_comb begin
    res_hi = prod_c[2*WIDTH-1:WIDTH];
    res_lo = prod_c[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        // The iteration still runs its full length; its result is discarded.
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_rem ? -step_hi : step_hi;
        res_lo = neg_res ? -step_lo : step_lo;
      end
    end
  end

  assign wr = (state == ST_RUN) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      m_op     <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= op[1] & a_neg;
            div_zero <= op[1] && (b == '0);
            a_raw    <= a;
            m_op     <= op[1] ? b_mag : a_mag;
            p_hi     <= '0;
            p_lo     <= op[1] ? a_mag : b_mag;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_hi <= step_hi;
          p_lo <= step_lo;
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_md.sv
// alu_md: EX-stage ALU with iterative multiply/divide and HI/LO registers.
//   clk, reset_n  clock, synchronous active-low reset
//   bus           alu_md_if.slave: combinational ALU (result + zero/more0/
//                 overflow flags), md_start/md_op -> md_busy/md_done,
//                 hi_we/lo_we moves from input_1, hi/lo register outputs
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic     clk,
  input logic     reset_n,
  alu_md_if.slave bus
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] vshamt;
  logic [WIDTH-1:0]   result;
  logic               ovf;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               md_busy;
  logic               md_done;
  logic               md_wr;
  logic               take_move;

  assign a      = bus.input_1;
  assign b      = bus.input_2;
  assign sum    = a + b;
  assign diff   = a - b;
  assign vshamt = a[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (bus.alu_op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL:  result = b << bus.shamt;
      ALU_SRL:  result = b >> bus.shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> bus.shamt);
      ALU_SLLV: result = b << vshamt;
      ALU_SRLV: result = b >> vshamt;
      ALU_SRAV: result = $unsigned($signed(b) >>> vshamt);
      ALU_LUI:  result = b << (WIDTH / 2);
      default:  result = '0;
    endcase
  end

  assign bus.alu_result = result;
  assign bus.overflow   = ovf;
  assign bus.zero       = (a == b);
  assign bus.more0      = !a[WIDTH-1] && (a != '0);

  md_iter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_md_iter (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (bus.md_start),
    .op     (md_op_e'(bus.md_op)),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .wr     (md_wr),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Moves are dropped while iterating and when a start is taken in the same
  // cycle; md_wr only occurs while busy, so it never collides with a move.
  assign take_move = !md_busy && !bus.md_start;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (take_move) begin
      if (bus.hi_we) hi_q <= a;
      if (bus.lo_we) lo_q <= a;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.md_busy = md_busy;
  assign bus.md_done = md_done;

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Combinational ALU path with a wider op set, WIDTH-generic, plus zero/sign/overflow flags.
- Iterative multiply/divide unit feeding HI/LO registers, with start/busy/done handshake.
- Sits in the EX stage. The controller stalls on md_busy and reads HI/LO via mfhi/mflo muxing outside this block.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, even).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- alu_op  in  4  combinational op select (codes below).
- input_1  in  WIDTH  operand A (rs).
- input_2  in  WIDTH  operand B (rt/imm).
- shamt  in  SHAMT_W  shift amount for immediate shifts.
- alu_result  out  WIDTH  combinational result.
- zero  out  1  input_1 == input_2.
- more0  out  1  input_1 > 0, signed.
- overflow  out  1  signed overflow on ADD/SUB only; 0 for other ops.
- md_start  in  1  request a mul/div op; accepted only when md_busy=0.
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- hi_we  in  1  mthi: hi <= input_1.
- lo_we  in  1  mtlo: lo <= input_1.
- md_busy  out  1  iteration in progress.
- md_done  out  1  one-cycle pulse when HI/LO updated by an op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- ALU op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0011 SLT (signed), 0111 SLTU.
  - 0100 XOR, 0101 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift input_2 by shamt.
  - 1011 SLLV, 1100 SRLV, 1101 SRAV: shift input_2 by input_1[SHAMT_W-1:0].
  - 1110 LUI: input_2 << WIDTH/2.
  - 1111: result all-zero.
- SLT/SLTU give a 1-bit result, zero-extended. ADD/SUB wrap modulo 2^WIDTH; overflow is flagged, never trapped here.
- Reset (reset_n=0 at a clk edge) clears: hi, lo, md_busy, md_done, internal counter, and partial results. Reset mid-operation aborts the op with no HI/LO update.
- FSM states:
  - IDLE: md_start=1 latches operands and op, then goes to RUN. md_busy=1 from the next cycle.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle for exactly WIDTH cycles, then FIN.
  - FIN: writes HI/LO, md_done=1 for that cycle, md_busy=0, returns to IDLE.
  - New start accepted in FIN.
- Latency: start sampled at edge k → md_done high during cycle k+WIDTH+1. HI/LO hold the new value from that cycle.
- Signed ops operate on magnitudes. Results are then corrected:
  - Product sign = sign(A) XOR sign(B).
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- MULT/MULTU: {hi,lo} = 2·WIDTH product. DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: lo = all-ones, hi = dividend (input_1). Same cycle count, no error flag.
- Signed DIV of most-negative by −1: lo = most-negative, hi = 0.
- md_start while md_busy=1: ignored, no queuing.
- hi_we/lo_we while md_busy=1: ignored.
- hi_we/lo_we in the same cycle as an accepted md_start: the move is ignored and the start wins.
- hi_we and lo_we together: both written.
- Operands are latched at start; later input changes do not affect the running op.

Decomposition:
- Package alu_md_pkg holds:
  - ALU op code constants.
  - md_op codes.
  - FSM state encoding (IDLE/RUN/FIN).
- One sub-module, md_iter: the iterative mul/div datapath plus counter.
- The top holds the combinational ALU, HI/LO registers, and move-port arbitration.

Test Plan (WIDTH=32):
- ALU sweep:
  - ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1.
  - SUB 0−1 → 0xFFFFFFFF, overflow=0.
  - SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI 0x1234 → 0x12340000.
- MULT −3×7, start at edge k:
  - md_busy cycles k+1..k+32; md_done at k+33.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=0x00000001.
- DIV:
  - −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 → lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Handshake:
  - Second md_start and hi_we pulsed mid-RUN → ignored; first result intact.
  - md_start in FIN cycle → accepted, second done 33 cycles later.
- Reset mid-op: reset_n=0 at cycle 10 of RUN → next cycle md_busy=0, hi=lo=0, no md_done pulse.
- mthi/mtlo: hi_we=lo_we=1, input_1=0xA5A5A5A5 while idle → both hi and lo = 0xA5A5A5A5 next cycle.
